cmd_rect: RTL and testbench

CMD_RECT -- requirements
Module: cmd_rect

---
 rtl/minigpu_pkg.sv | 23 ++
 rtl/rect_scan.sv | 65 ++++++
 rtl/cmd_rect.sv | 191 +++++++++++++++++++
 tb/tb_cmd_rect.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/minigpu_pkg.sv
// -----------------------------------------------------------------------------
// minigpu_pkg
// Shared constants and types for the mini GPU command blocks.
//   FB_W, FB_H     : framebuffer size in pixels (FB_W is a power of two)
//   BASE_ADDR      : byte offset of buffer half 1 in VRAM
//   VRAM_ADDR_W    : VRAM address width
//   rect_state_t   : state encoding of the rectangle fill engine
// -----------------------------------------------------------------------------
package minigpu_pkg;

   localparam int FB_W        = 256;
   localparam int FB_H        = 192;
   localparam int VRAM_ADDR_W = 18;
   localparam logic [VRAM_ADDR_W-1:0] BASE_ADDR = 18'd49152;

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      FILL,
      DONE
   } rect_state_t;

endpackage

// File: rtl/rect_scan.sv
// -----------------------------------------------------------------------------
// rect_scan
// Row-major raster counters for the rectangle engine.
// Ports:
//   CLK, rst         : clock, asynchronous active-high reset
//   i_start          : load the counters with (i_x0, i_y0)
//   i_step           : advance one pixel (x first, wrapping into the next row)
//   i_x0, i_y0       : top-left corner of the scan
//   i_xe, i_ye       : exclusive right/bottom bounds (already clipped)
//   o_x, o_y         : current pixel
//   o_lastPixel      : current pixel is (i_xe-1, i_ye-1)
//   o_onEdge         : current pixel lies on the rectangle border
// -----------------------------------------------------------------------------
module rect_scan #(
   parameter int CW = 10
) (
   input  logic          CLK,
   input  logic          rst,
   input  logic          i_start,
   input  logic          i_step,
   input  logic [CW-1:0] i_x0,
   input  logic [CW-1:0] i_y0,
   input  logic [CW-1:0] i_xe,
   input  logic [CW-1:0] i_ye,
   output logic [CW-1:0] o_x,
   output logic [CW-1:0] o_y,
   output logic          o_lastPixel,
   output logic          o_onEdge
);

   logic [CW-1:0] r_x;
   logic [CW-1:0] r_y;
   logic [CW-1:0] w_xLast;
   logic [CW-1:0] w_yLast;
   logic          w_rowEnd;

   assign w_xLast  = i_xe - CW'(1);
   assign w_yLast  = i_ye - CW'(1);
   assign w_rowEnd = (r_x == w_xLast);

   // x runs across the row; on the last column it snaps back to the left edge
   // and y moves down one row.
   always_ff @(posedge CLK or posedge rst) begin
      if (rst) begin
         r_x <= '0;
         r_y <= '0;
      end else if (i_start) begin
         r_x <= i_x0;
         r_y <= i_y0;
      end else if (i_step) begin
         if (w_rowEnd) begin
            r_x <= i_x0;
            r_y <= r_y + CW'(1);
         end else begin
            r_x <= r_x + CW'(1);
         end
      end
   end

   assign o_x         = r_x;
   assign o_y         = r_y;
   assign o_lastPixel = w_rowEnd && (r_y == w_yLast);
   assign o_onEdge    = (r_x == i_x0) || w_rowEnd || (r_y == i_y0) || (r_y == w_yLast);

endmodule

// File: rtl/cmd_rect.sv
// -----------------------------------------------------------------------------
// cmd_rect
// Fills (or, optionally, outlines) a clipped rectangle in the back buffer
// through VRAM port B, one pixel per clock.
// Ports:
//   CLK, rst             : clock, asynchronous active-high reset
//   rect_req_pulse       : one-cycle start strobe, honoured only when idle
//   side                 : displayed buffer; writes go to the other half
//   x0, y0, w, h, color  : rectangle origin, size and fill byte
//   outline              : draw border only (present with CMD_RECT_OUTLINE_EN)
//   vram_addr_b/data_b/we_b : registered VRAM port-B write interface
//   BUSY                 : high from the accepted request through DONE
// Configuration macro: CMD_RECT_OUTLINE_EN adds the outline input and logic.
// -----------------------------------------------------------------------------
module cmd_rect #(
   parameter int          FB_W      = minigpu_pkg::FB_W,
   parameter int          FB_H      = minigpu_pkg::FB_H,
   parameter logic [17:0] BASE_ADDR = minigpu_pkg::BASE_ADDR
) (
   input  logic        CLK,
   input  logic        rst,
   input  logic        rect_req_pulse,
   input  logic        side,
   input  logic [7:0]  x0,
   input  logic [7:0]  y0,
   input  logic [8:0]  w,
   input  logic [8:0]  h,
   input  logic [7:0]  color,
`ifdef CMD_RECT_OUTLINE_EN
   input  logic        outline,
`endif
   output logic [17:0] vram_addr_b,
   output logic [7:0]  vram_data_b,
   output logic        vram_we_b,
   output logic        BUSY
);

   localparam int            CW      = 10;
   localparam int            SHIFT   = $clog2(FB_W);
   localparam logic [CW-1:0] FB_W_C  = CW'(FB_W);
   localparam logic [CW-1:0] FB_H_C  = CW'(FB_H);

   minigpu_pkg::rect_state_t r_state;
   minigpu_pkg::rect_state_t w_nextState;

   logic          r_side;
   logic [7:0]    r_x0;
   logic [7:0]    r_y0;
   logic [8:0]    r_w;
   logic [8:0]    r_h;
   logic [7:0]    r_color;
   logic [CW-1:0] r_xe;
   logic [CW-1:0] r_ye;
   logic [17:0]   r_addr;
   logic [7:0]    r_data;
   logic          r_we;

   logic [CW-1:0] w_xSum;
   logic [CW-1:0] w_ySum;
   logic [CW-1:0] w_xe;
   logic [CW-1:0] w_ye;
   logic          w_empty;
   logic [CW-1:0] w_x;
   logic [CW-1:0] w_y;
   logic          w_lastPixel;
   logic          w_onEdge;
   logic          w_paint;
   logic [17:0]   w_pixAddr;

   // Clipping uses 10-bit sums so x0+w and y0+h cannot wrap.
   assign w_xSum  = {2'b00, r_x0} + {1'b0, r_w};
   assign w_ySum  = {2'b00, r_y0} + {1'b0, r_h};
   assign w_xe    = (w_xSum > FB_W_C) ? FB_W_C : w_xSum;
   assign w_ye    = (w_ySum > FB_H_C) ? FB_H_C : w_ySum;
   assign w_empty = (r_w == 9'd0) || (r_h == 9'd0) ||
                    ({2'b00, r_x0} >= FB_W_C) || ({2'b00, r_y0} >= FB_H_C);

   // State register.
   always_ff @(posedge CLK or posedge rst) begin
      if (rst) begin
         r_state <= minigpu_pkg::IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state logic; requests outside IDLE are simply dropped.
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         minigpu_pkg::IDLE:  if (rect_req_pulse) w_nextState = minigpu_pkg::SETUP;
         minigpu_pkg::SETUP: w_nextState = w_empty ? minigpu_pkg::DONE : minigpu_pkg::FILL;
         minigpu_pkg::FILL:  if (w_lastPixel) w_nextState = minigpu_pkg::DONE;
         minigpu_pkg::DONE:  w_nextState = minigpu_pkg::IDLE;
         default:            w_nextState = minigpu_pkg::IDLE;
      endcase
   end

   // Arguments are captured once so later input changes (including side
   // toggles by the buffer swapper) cannot disturb a running operation.
   always_ff @(posedge CLK or posedge rst) begin
      if (rst) begin
         r_side  <= 1'b0;
         r_x0    <= '0;
         r_y0    <= '0;
         r_w     <= '0;
         r_h     <= '0;
         r_color <= '0;
      end else if ((r_state == minigpu_pkg::IDLE) && rect_req_pulse) begin
         r_side  <= side;
         r_x0    <= x0;
         r_y0    <= y0;
         r_w     <= w;
         r_h     <= h;
         r_color <= color;
      end
   end

   // Clipped bounds are frozen during SETUP for use by the scanner.
   always_ff @(posedge CLK or posedge rst) begin
      if (rst) begin
         r_xe <= '0;
         r_ye <= '0;
      end else if (r_state == minigpu_pkg::SETUP) begin
         r_xe <= w_xe;
         r_ye <= w_ye;
      end
   end

   rect_scan #(
      .CW (CW)
   ) u_scan (
      .CLK         (CLK),
      .rst         (rst),
      .i_start     (r_state == minigpu_pkg::SETUP),
      .i_step      (r_state == minigpu_pkg::FILL),
      .i_x0        ({2'b00, r_x0}),
      .i_y0        ({2'b00, r_y0}),
      .i_xe        (r_xe),
      .i_ye        (r_ye),
      .o_x         (w_x),
      .o_y         (w_y),
      .o_lastPixel (w_lastPixel),
      .o_onEdge    (w_onEdge)
   );

`ifdef CMD_RECT_OUTLINE_EN
   logic r_outline;

   always_ff @(posedge CLK or posedge rst) begin
      if (rst) begin
         r_outline <= 1'b0;
      end else if ((r_state == minigpu_pkg::IDLE) && rect_req_pulse) begin
         r_outline <= outline;
      end
   end

   // Interior pixels are still scanned, just not written.
   assign w_paint = r_outline ? w_onEdge : 1'b1;
`else
   logic w_unusedOnEdge;

   assign w_unusedOnEdge = w_onEdge;
   assign w_paint        = 1'b1;
`endif

   // Back buffer is the half not being displayed; row offset is a shift.
   assign w_pixAddr = (r_side ? 18'd0 : BASE_ADDR) + (18'(w_y) << SHIFT) + 18'(w_x);

   // Registered write port: a pixel scanned this cycle appears next cycle,
   // so the final pixel is written while the FSM sits in DONE.
   always_ff @(posedge CLK or posedge rst) begin
      if (rst) begin
         r_we   <= 1'b0;
         r_addr <= '0;
         r_data <= '0;
      end else begin
         r_we <= (r_state == minigpu_pkg::FILL) && w_paint;
         if (r_state == minigpu_pkg::FILL) begin
            r_addr <= w_pixAddr;
            r_data <= r_color;
         end
      end
   end

   assign vram_addr_b = r_addr;
   assign vram_data_b = r_data;
   assign vram_we_b   = r_we;
   assign BUSY        = (r_state != minigpu_pkg::IDLE);

endmodule

// File: tb/tb_cmd_rect.sv
// -----------------------------------------------------------------------------
// tb_cmd_rect
// Scoreboard bench for cmd_rect. Each request pushes its expected writes
// (address, data, cycle) into a queue; a monitor pops them as writes appear.
// Build with CMD_RECT_OUTLINE_EN defined to exercise the outline mode.
// -----------------------------------------------------------------------------
module tb_cmd_rect;

   localparam int FBW  = 256;
   localparam int FBH  = 192;
   localparam int BASE = 49152;

   logic        CLK = 1'b0;
   logic        rst;
   logic        rect_req_pulse;
   logic        side;
   logic [7:0]  x0;
   logic [7:0]  y0;
   logic [8:0]  w;
   logic [8:0]  h;
   logic [7:0]  color;
`ifdef CMD_RECT_OUTLINE_EN
   logic        outline;
`endif
   logic [17:0] vram_addr_b;
   logic [7:0]  vram_data_b;
   logic        vram_we_b;
   logic        BUSY;

   typedef struct {
      int addr;
      int data;
      int cyc;
   } exp_t;

   exp_t scb[$];
   int   checks     = 0;
   int   failures   = 0;
   int   writesSeen = 0;
   int   cyc        = 0;

   cmd_rect dut (
      .CLK            (CLK),
      .rst            (rst),
      .rect_req_pulse (rect_req_pulse),
      .side           (side),
      .x0             (x0),
      .y0             (y0),
      .w              (w),
      .h              (h),
      .color          (color),
`ifdef CMD_RECT_OUTLINE_EN
      .outline        (outline),
`endif
      .vram_addr_b    (vram_addr_b),
      .vram_data_b    (vram_data_b),
      .vram_we_b      (vram_we_b),
      .BUSY           (BUSY)
   );

   always #5 CLK = ~CLK;

   // Cycle index, advanced at each rising edge.
   initial begin
      forever begin
         @(posedge CLK);
         cyc = cyc + 1;
      end
   end

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, expected);
      end
   endtask

   // Reference: enumerate the clipped rectangle row by row; scanned pixel k
   // of a request made in cycle n shows up on the port in cycle n+3+k.
   function automatic void model(input bit s, input int ax0, input int ay0, input int aw,
                                 input int ah, input int col, input bit ol, input int n,
                                 output int npix, output int nwr);
      int   xe;
      int   ye;
      bit   edgePix;
      exp_t e;
      npix = 0;
      nwr  = 0;
      if (aw == 0 || ah == 0 || ax0 >= FBW || ay0 >= FBH) return;
      xe = (ax0 + aw > FBW) ? FBW : ax0 + aw;
      ye = (ay0 + ah > FBH) ? FBH : ay0 + ah;
      for (int yy = ay0; yy < ye; yy++) begin
         for (int xx = ax0; xx < xe; xx++) begin
            edgePix = (xx == ax0) || (xx == xe - 1) || (yy == ay0) || (yy == ye - 1);
            if (!ol || edgePix) begin
               e.addr = (s ? 0 : BASE) + yy * FBW + xx;
               e.data = col;
               e.cyc  = n + 3 + npix;
               scb.push_back(e);
               nwr++;
            end
            npix++;
         end
      end
   endfunction

   // Monitor: every write on port B must match the head of the scoreboard.
   initial begin
      exp_t e;
      forever begin
         @(negedge CLK);
         if (rst !== 1'b1 && vram_we_b === 1'b1) begin
            writesSeen++;
            if (scb.size() == 0) begin
               checks++;
               failures++;
               $display("[TB] FAIL unexpected_write actual_addr=%0d required=no_write", vram_addr_b);
            end else begin
               e = scb.pop_front();
               checkOutput("write_addr", int'(vram_addr_b), e.addr);
               checkOutput("write_data", int'(vram_data_b), e.data);
               checkOutput("write_cycle", cyc, e.cyc);
            end
         end
      end
   end

   // Issue one request and follow it to the end. interfereAt>0 fires a
   // stray request and a side toggle at that BUSY cycle; resetAtWrite>0
   // asserts rst once that many writes have appeared.
   task automatic applyStimulus(input bit s, input int ax0, input int ay0, input int aw,
                                input int ah, input int col, input bit ol,
                                input int interfereAt, input int resetAtWrite,
                                output int busyOut, output int wrOut);
      int n;
      int npix;
      int nwr;
      int busyCnt;
      int startWr;
      bit done;
      @(posedge CLK);
      #1;
      side  = s;
      x0    = 8'(ax0);
      y0    = 8'(ay0);
      w     = 9'(aw);
      h     = 9'(ah);
      color = 8'(col);
`ifdef CMD_RECT_OUTLINE_EN
      outline = ol;
`endif
      rect_req_pulse = 1'b1;
      n       = cyc;
      startWr = writesSeen;
      model(s, ax0, ay0, aw, ah, col, ol, n, npix, nwr);
      @(posedge CLK);
      #1;
      rect_req_pulse = 1'b0;
      busyCnt = 0;
      done    = 1'b0;
      for (int i = 0; i < 20000 && !done; i++) begin
         @(negedge CLK);
         #2;
         if (BUSY) busyCnt++;
         else done = 1'b1;
         if (rect_req_pulse) begin
            rect_req_pulse = 1'b0;
         end else if (!done && interfereAt > 0 && busyCnt == interfereAt) begin
            rect_req_pulse = 1'b1;
            side           = ~side;
            x0             = 8'($urandom);
            w              = 9'($urandom_range(1, 100));
         end
         if (!done && resetAtWrite > 0 && (writesSeen - startWr) == resetAtWrite) begin
            rst = 1'b1;
            #1;
            checkOutput("rst_we", int'(vram_we_b), 0);
            checkOutput("rst_busy", int'(BUSY), 0);
            checkOutput("rst_addr", int'(vram_addr_b), 0);
            checkOutput("rst_data", int'(vram_data_b), 0);
            scb.delete();
            @(negedge CLK);
            @(negedge CLK);
            #2;
            checkOutput("rst_no_more_writes", writesSeen - startWr, resetAtWrite);
            checkOutput("rst_busy_held", int'(BUSY), 0);
            rst  = 1'b0;
            done = 1'b1;
         end
      end
      if (!done) begin
         checks++;
         failures++;
         $display("[TB] FAIL busy_timeout actual=still_busy required=idle");
      end else if (resetAtWrite == 0) begin
         checkOutput("busy_cycles", busyCnt, npix + 2);
         checkOutput("write_count", writesSeen - startWr, nwr);
      end
      busyOut = busyCnt;
      wrOut   = writesSeen - startWr;
   endtask

   initial begin
      int b;
      int wr;
      int rx;
      int ry;
      int rw;
      int rh;
      bit ro;
      rst            = 1'b1;
      rect_req_pulse = 1'b0;
      side           = 1'b0;
      x0             = '0;
      y0             = '0;
      w              = '0;
      h              = '0;
      color          = '0;
`ifdef CMD_RECT_OUTLINE_EN
      outline        = 1'b0;
`endif
      repeat (3) @(negedge CLK);
      checkOutput("reset_busy", int'(BUSY), 0);
      checkOutput("reset_we", int'(vram_we_b), 0);
      checkOutput("reset_addr", int'(vram_addr_b), 0);
      checkOutput("reset_data", int'(vram_data_b), 0);
      #2;
      rst = 1'b0;

      $display("[TB] basic 3x2 fill");
      applyStimulus(1'b0, 10, 20, 3, 2, 8'h5A, 1'b0, 0, 0, b, wr);
      checkOutput("basic_busy", b, 8);
      checkOutput("basic_writes", wr, 6);

      $display("[TB] clipped corner fill");
      applyStimulus(1'b1, 254, 190, 5, 5, 8'hC3, 1'b0, 0, 0, b, wr);
      checkOutput("clip_busy", b, 6);
      checkOutput("clip_writes", wr, 4);

      $display("[TB] degenerate requests");
      applyStimulus(1'b0, 50, 60, 0, 7, 8'h21, 1'b0, 0, 0, b, wr);
      checkOutput("zero_w_busy", b, 2);
      checkOutput("zero_w_writes", wr, 0);
      applyStimulus(1'b1, 200, 192, 5, 5, 8'h22, 1'b0, 0, 0, b, wr);
      checkOutput("off_y_busy", b, 2);
      checkOutput("off_y_writes", wr, 0);

      $display("[TB] stray request and side toggle during fill");
      applyStimulus(1'b0, 30, 40, 5, 3, 8'h11, 1'b0, 3, 0, b, wr);
      checkOutput("interfere_busy", b, 17);
      checkOutput("interfere_writes", wr, 15);

      $display("[TB] reset at third write of 4x4");
      applyStimulus(1'b0, 100, 100, 4, 4, 8'h77, 1'b0, 0, 3, b, wr);
      applyStimulus(1'b0, 100, 100, 4, 4, 8'h78, 1'b0, 0, 0, b, wr);
      checkOutput("after_rst_busy", b, 18);
      checkOutput("after_rst_writes", wr, 16);

      $display("[TB] 4x3 at origin");
      applyStimulus(1'b1, 0, 0, 4, 3, 8'hFF, 1'b0, 0, 0, b, wr);
      checkOutput("fill43_busy", b, 14);
      checkOutput("fill43_writes", wr, 12);
`ifdef CMD_RECT_OUTLINE_EN
      applyStimulus(1'b1, 0, 0, 4, 3, 8'hEE, 1'b1, 0, 0, b, wr);
      checkOutput("outline43_busy", b, 14);
      checkOutput("outline43_writes", wr, 10);
`endif

      $display("[TB] randomized requests");
      for (int k = 0; k < 25; k++) begin
         rx = $urandom_range(0, 255);
         ry = $urandom_range(0, 200);
         rw = $urandom_range(0, 24);
         rh = $urandom_range(0, 12);
         if ($urandom_range(0, 3) == 0) rw = $urandom_range(250, 511);
`ifdef CMD_RECT_OUTLINE_EN
         ro = 1'($urandom_range(0, 1));
`else
         ro = 1'b0;
`endif
         applyStimulus(1'($urandom_range(0, 1)), rx, ry, rw, rh, int'($urandom_range(0, 255)),
                       ro, 0, 0, b, wr);
      end

      repeat (4) @(negedge CLK);
      checkOutput("scoreboard_drained", scb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
